// File: rtl/e203_dtcm_icb2ram_pkg.sv
// Shared widths, FSM encoding and response bookkeeping for the DTCM ICB-to-SRAM bridge.
package e203_dtcm_icb2ram_pkg;

    localparam int unsigned E203_DTCM_RAM_AW = 13;
    localparam int unsigned E203_DTCM_RAM_DW = 32;
    localparam int unsigned E203_DTCM_RAM_MW = 4;
    localparam int unsigned LS_CNT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RSP  = 2'd1,
        ST_HOLD = 2'd2
    } icb_state_t;

    // What the outstanding response must return
    typedef struct packed {
        logic rd;
        logic err;
    } rsp_info_t;

endpackage

// File: rtl/e203_dtcm_icb2ram_if.sv
// ICB command/response channel between a bus master and the DTCM bridge.
interface e203_dtcm_icb2ram_if #(
    parameter int unsigned AW = e203_dtcm_icb2ram_pkg::E203_DTCM_RAM_AW,
    parameter int unsigned DW = e203_dtcm_icb2ram_pkg::E203_DTCM_RAM_DW,
    parameter int unsigned MW = e203_dtcm_icb2ram_pkg::E203_DTCM_RAM_MW
) ();
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW+2:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [DW-1:0] icb_cmd_wdata;
    logic [MW-1:0] icb_cmd_wmask;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [DW-1:0] icb_rsp_rdata;
    logic          icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface

// File: rtl/e203_dtcm_ls_ctrl.sv
// Idle counter and SRAM light-sleep control with a one-cycle wake-up window.
module e203_dtcm_ls_ctrl import e203_dtcm_icb2ram_pkg::*; #(
    parameter int unsigned LS_IDLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic st_idle,
    input  logic cmd_valid,
    output logic ram_ls,
    output logic ls_active
);
    localparam logic [LS_CNT_W-1:0] LS_MAX = LS_CNT_W'(LS_IDLE);

    logic [LS_CNT_W-1:0] idle_cnt;
    logic                wake;

    assign ram_ls    = (idle_cnt == LS_MAX);
    assign ls_active = ram_ls | wake;

    // Count quiet idle cycles, saturating at the sleep threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (st_idle && !cmd_valid) begin
            if (!ram_ls) begin
                idle_cnt <= idle_cnt + LS_CNT_W'(1);
            end
        end else begin
            idle_cnt <= '0;
        end
    end

    // Keep the bus stalled for the cycle in which the SRAM leaves light sleep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wake <= 1'b0;
        end else begin
            wake <= ram_ls & cmd_valid;
        end
    end
endmodule

// File: rtl/e203_dtcm_icb2ram.sv
// DTCM bridge: ICB commands to single-port SRAM with latency-1 responses and back-pressure hold.
module e203_dtcm_icb2ram import e203_dtcm_icb2ram_pkg::*; #(
    parameter int unsigned AW      = E203_DTCM_RAM_AW,
    parameter int unsigned DW      = E203_DTCM_RAM_DW,
    parameter int unsigned MW      = E203_DTCM_RAM_MW,
    parameter int unsigned LS_IDLE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    e203_dtcm_icb2ram_if.slave     icb,
    output logic                   ram_cs,
    output logic                   ram_we,
    output logic [AW-1:0]          ram_addr,
    output logic [MW-1:0]          ram_wem,
    output logic [DW-1:0]          ram_din,
    input  logic [DW-1:0]          ram_dout,
    output logic                   ram_ls,
    output logic                   ram_ds,
    output logic                   ram_sd
);
    icb_state_t    state;
    icb_state_t    state_nxt;
    rsp_info_t     rsp_info;
    logic [DW-1:0] hold_data;
    logic          ls_active;
    logic          in_range;
    logic          rsp_hs;
    logic          cmd_hs;
    logic          addr_lsb_unused;

    // Byte-offset bits are irrelevant for word-wide SRAM access
    assign addr_lsb_unused = ^icb.icb_cmd_addr[1:0];

    assign in_range          = ~icb.icb_cmd_addr[AW+2];
    assign rsp_hs            = (state != ST_IDLE) & icb.icb_rsp_ready;
    assign icb.icb_cmd_ready = ~ls_active & ((state == ST_IDLE) | rsp_hs);
    assign cmd_hs            = icb.icb_cmd_valid & icb.icb_cmd_ready;

    // SRAM strobes go out in the acceptance cycle so data returns next cycle
    assign ram_cs   = cmd_hs & in_range;
    assign ram_we   = ram_cs & ~icb.icb_cmd_read;
    assign ram_addr = icb.icb_cmd_addr[AW+1:2];
    assign ram_wem  = icb.icb_cmd_wmask;
    assign ram_din  = icb.icb_cmd_wdata;
    assign ram_ds   = 1'b0;
    assign ram_sd   = 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and response outputs
    always_comb begin
        state_nxt         = state;
        icb.icb_rsp_valid = 1'b0;
        icb.icb_rsp_rdata = '0;
        icb.icb_rsp_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_hs) state_nxt = ST_RSP;
            end
            ST_RSP: begin
                icb.icb_rsp_valid = 1'b1;
                icb.icb_rsp_rdata = rsp_info.rd ? ram_dout : '0;
                icb.icb_rsp_err   = rsp_info.err;
                if (icb.icb_rsp_ready) state_nxt = cmd_hs ? ST_RSP : ST_IDLE;
                else                   state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                icb.icb_rsp_valid = 1'b1;
                icb.icb_rsp_rdata = hold_data;
                icb.icb_rsp_err   = rsp_info.err;
                if (icb.icb_rsp_ready) state_nxt = cmd_hs ? ST_RSP : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Remember what kind of response the accepted command needs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_info <= '0;
        end else if (cmd_hs) begin
            rsp_info <= '{rd: icb.icb_cmd_read & in_range, err: ~in_range};
        end
    end

    // Freeze read data when the master stalls, since ram_dout may move on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
        end else if ((state == ST_RSP) && !icb.icb_rsp_ready) begin
            hold_data <= rsp_info.rd ? ram_dout : '0;
        end
    end

    e203_dtcm_ls_ctrl #(.LS_IDLE(LS_IDLE)) u_ls_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_idle   (state == ST_IDLE),
        .cmd_valid (icb.icb_cmd_valid),
        .ram_ls    (ram_ls),
        .ls_active (ls_active)
    );
endmodule

// File: tb/tb_e203_dtcm_icb2ram.sv
// Bench for the DTCM ICB-to-SRAM bridge: SRAM environment, transaction-level model, directed scenarios.
module tb_e203_dtcm_icb2ram;
    localparam int AW      = 13;
    localparam int DW      = 32;
    localparam int MW      = 4;
    localparam int LS_IDLE = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din, ram_dout;

    e203_dtcm_icb2ram_if #(.AW(AW), .DW(DW), .MW(MW)) icb ();

    e203_dtcm_icb2ram #(.AW(AW), .DW(DW), .MW(MW), .LS_IDLE(LS_IDLE)) dut (
        .clk(clk), .rst_n(rst_n), .icb(icb),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // SRAM environment: registered read data, optional corruption of dout
    logic [DW-1:0] sram [0:(1<<AW)-1] = '{default: '0};
    logic [DW-1:0] dout_q  = '0;
    logic          corrupt = 1'b0;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) sram[ram_addr] <= merge(sram[ram_addr], ram_din, ram_wem);
            else        dout_q <= sram[ram_addr];
        end
    end
    assign ram_dout = corrupt ? 32'h1234_5678 : dout_q;

    // Transaction-level model: pending responses, memory image, quiet-cycle count
    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    rsp_t        q[$];
    rsp_t        m_r;
    logic [31:0] mdl_mem [int];
    int          quiet = 0;
    bit          wake = 0, m_sleep, m_rdy, m_acc, m_inr;
    int          m_idx;

    function automatic logic [31:0] rd_mem(input int a);
        return mdl_mem.exists(a) ? mdl_mem[a] : 32'h0;
    endfunction

    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            q.delete();
            quiet = 0;
            wake  = 0;
            chk("rst_rsp_valid", icb.icb_rsp_valid, 0);
            chk("rst_rsp_rdata", icb.icb_rsp_rdata, 0);
            chk("rst_rsp_err", icb.icb_rsp_err, 0);
            chk("rst_ram_ls", ram_ls, 0);
            chk("rst_ram_cs", ram_cs, 0);
            chk("rst_ram_we", ram_we, 0);
        end else begin
            m_sleep = (quiet >= LS_IDLE);
            m_rdy   = !m_sleep && !wake && (q.size() == 0 || icb.icb_rsp_ready);
            m_acc   = icb.icb_cmd_valid && m_rdy;
            m_inr   = !icb.icb_cmd_addr[AW+2];
            m_idx   = int'(icb.icb_cmd_addr[AW+1:2]);
            chk("cmd_ready", icb.icb_cmd_ready, m_rdy);
            chk("ram_ls", ram_ls, m_sleep);
            chk("rsp_valid", icb.icb_rsp_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("rsp_rdata", icb.icb_rsp_rdata, q[0].rdata);
                chk("rsp_err", icb.icb_rsp_err, q[0].err);
            end
            chk("ram_cs", ram_cs, m_acc && m_inr);
            chk("ram_we", ram_we, m_acc && m_inr && !icb.icb_cmd_read);
            if (m_acc && m_inr) begin
                chk("ram_addr", ram_addr, icb.icb_cmd_addr[AW+1:2]);
                chk("ram_wem", ram_wem, icb.icb_cmd_wmask);
                chk("ram_din", ram_din, icb.icb_cmd_wdata);
            end
            chk("ram_ds", ram_ds, 0);
            chk("ram_sd", ram_sd, 0);
            // advance to the next cycle
            if (q.size() == 0 && !icb.icb_cmd_valid) begin
                if (quiet < LS_IDLE) quiet++;
            end else begin
                quiet = 0;
            end
            wake = m_sleep && icb.icb_cmd_valid;
            if (q.size() != 0 && icb.icb_rsp_ready) void'(q.pop_front());
            if (m_acc) begin
                m_r.err   = !m_inr;
                m_r.rdata = (m_inr && icb.icb_cmd_read) ? rd_mem(m_idx) : 32'h0;
                q.push_back(m_r);
                if (m_inr && !icb.icb_cmd_read)
                    mdl_mem[m_idx] = merge(rd_mem(m_idx), icb.icb_cmd_wdata, icb.icb_cmd_wmask);
            end
        end
    end

    task automatic set_cmd(input logic rd, input logic [AW+2:0] a, input logic [31:0] wd, input logic [3:0] wm);
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = rd;
        icb.icb_cmd_addr  = a;
        icb.icb_cmd_wdata = wd;
        icb.icb_cmd_wmask = wm;
    endtask

    // Present a command from a negedge until accepted; returns at the following negedge
    task automatic send(input logic rd, input logic [AW+2:0] a, input logic [31:0] wd, input logic [3:0] wm);
        bit done = 0;
        set_cmd(rd, a, wd, wm);
        for (int i = 0; i < 40 && !done; i++) begin
            #3;
            if (icb.icb_cmd_ready === 1'b1) done = 1;
            @(negedge clk);
        end
        icb.icb_cmd_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout: addr 0x%0h not accepted, required within 40 cycles", a);
        end
    endtask

    initial begin
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = '0;
        icb.icb_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #3 chk("ready_after_reset", icb.icb_cmd_ready, 1);

        // Write then read back 0x0010
        @(negedge clk);
        send(1'b0, 16'h0010, 32'hDEAD_BEEF, 4'hF);
        set_cmd(1'b1, 16'h0010, 32'h0, 4'hF);
        #3 chk("rd10_ram_addr", ram_addr, 4);
        chk("rd10_ram_wem", ram_wem, 4'hF);
        chk("rd10_ram_cs", ram_cs, 1);
        @(negedge clk); icb.icb_cmd_valid = 1'b0;
        #3 chk("rd10_rsp_valid", icb.icb_rsp_valid, 1);
        chk("rd10_rdata", icb.icb_rsp_rdata, 32'hDEAD_BEEF);
        chk("rd10_err", icb.icb_rsp_err, 0);

        // Stalled response: held data survives a changing ram_dout
        @(negedge clk); icb.icb_rsp_ready = 1'b0;
        set_cmd(1'b1, 16'h0010, 32'h0, 4'hF);
        #3 chk("hold_accept", icb.icb_cmd_ready, 1);
        @(negedge clk); icb.icb_cmd_valid = 1'b0;
        #3 chk("hold_rsp0", icb.icb_rsp_rdata, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); corrupt = 1'b1;
            set_cmd(1'b1, 16'h0004, 32'h0, 4'hF);
            #3 chk("hold_rdata", icb.icb_rsp_rdata, 32'hDEAD_BEEF);
            chk("hold_ready", icb.icb_cmd_ready, 0);
            chk("hold_valid", icb.icb_rsp_valid, 1);
        end
        @(negedge clk); icb.icb_rsp_ready = 1'b1; corrupt = 1'b0;
        #3 chk("hold_release_ready", icb.icb_cmd_ready, 1);
        @(negedge clk); icb.icb_cmd_valid = 1'b0;
        #3 chk("hold_next_rdata", icb.icb_rsp_rdata, 32'h0);
        @(negedge clk);
        #3 chk("hold_done_valid", icb.icb_rsp_valid, 0);

        // Back-to-back writes (including a partial mask) and reads
        @(negedge clk);
        send(1'b0, 16'h0000, 32'h1111_1111, 4'hF);
        send(1'b0, 16'h0004, 32'h2222_2222, 4'hF);
        send(1'b0, 16'h0008, 32'h3333_3333, 4'hF);
        send(1'b0, 16'h0008, 32'hAABB_CCDD, 4'b0110);
        set_cmd(1'b1, 16'h0000, 32'h0, 4'hF);
        #3 chk("b2b_rdy0", icb.icb_cmd_ready, 1);
        @(negedge clk); icb.icb_cmd_addr = 16'h0004;
        #3 chk("b2b_rdy1", icb.icb_cmd_ready, 1);
        chk("b2b_rdata0", icb.icb_rsp_rdata, 32'h1111_1111);
        @(negedge clk); icb.icb_cmd_addr = 16'h0008;
        #3 chk("b2b_rdy2", icb.icb_cmd_ready, 1);
        chk("b2b_rdata1", icb.icb_rsp_rdata, 32'h2222_2222);
        @(negedge clk); icb.icb_cmd_valid = 1'b0;
        #3 chk("b2b_valid2", icb.icb_rsp_valid, 1);
        chk("b2b_rdata2", icb.icb_rsp_rdata, 32'h33BB_CC33);

        // Out-of-range read and write
        @(negedge clk);
        set_cmd(1'b1, 16'h8010, 32'h0, 4'hF);
        #3 chk("oor_rd_cs", ram_cs, 0);
        @(negedge clk);
        set_cmd(1'b0, 16'h8020, 32'hFFFF_FFFF, 4'hF);
        #3 chk("oor_rd_err", icb.icb_rsp_err, 1);
        chk("oor_rd_rdata", icb.icb_rsp_rdata, 0);
        chk("oor_wr_we", ram_we, 0);
        @(negedge clk); icb.icb_cmd_valid = 1'b0;
        #3 chk("oor_wr_err", icb.icb_rsp_err, 1);
        chk("oor_wr_rdata", icb.icb_rsp_rdata, 0);

        // Light sleep after 16 quiet idle cycles, then wake-up
        @(negedge clk);
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) @(negedge clk);
            #3 chk("ls_count", ram_ls, (i == 16) ? 1 : 0);
        end
        @(negedge clk);
        set_cmd(1'b1, 16'h0010, 32'h0, 4'hF);
        #3 chk("wake0_ready", icb.icb_cmd_ready, 0);
        chk("wake0_ls", ram_ls, 1);
        @(negedge clk);
        #3 chk("wake1_ready", icb.icb_cmd_ready, 0);
        chk("wake1_ls", ram_ls, 0);
        @(negedge clk);
        #3 chk("wake2_ready", icb.icb_cmd_ready, 1);
        @(negedge clk); icb.icb_cmd_valid = 1'b0;
        #3 chk("wake_rdata", icb.icb_rsp_rdata, 32'hDEAD_BEEF);

        // Reset while a response is held
        @(negedge clk); icb.icb_rsp_ready = 1'b0;
        set_cmd(1'b1, 16'h0004, 32'h0, 4'hF);
        @(negedge clk); icb.icb_cmd_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_hold_valid", icb.icb_rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        icb.icb_rsp_ready = 1'b1;
        #3 chk("rst_rel_ready", icb.icb_cmd_ready, 1);
        chk("rst_rel_valid", icb.icb_rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3 chk("rst_no_stale", icb.icb_rsp_valid, 0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
